// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree (NUM_IN lanes per beat) followed
// by a group accumulator that sums beats between first/last markers.
// Optional feature macro: ADDER_TREE_ACC_SAT_EN (clamp result to OUT_W, drive ovf_o).
module adder_tree_acc #(
  parameter int NUM_IN = 9,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 20,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic [NUM_IN*IN_W-1:0] din,
  output logic [OUT_W-1:0]       acc_o,
  output logic [CNT_W-1:0]       cnt_o,
  output logic                   ovf_o,
  output logic                   vld_o,
  output logic                   vld_o_prev
);

  localparam int L  = $clog2(NUM_IN);
  localparam int TW = IN_W + L;        // tree width: one growth bit per level
  localparam int NA = 2 * NUM_IN;      // padded operand slots so pair indices stay in range

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  typedef logic signed [TW-1:0] tw_t;

  tw_t lvl_s  [0:L][0:NA-1];
  tw_t tree_d [1:L][0:NUM_IN-1];
  tw_t tree_q [1:L][0:NUM_IN-1];

  logic [L-1:0] vld_sr_d, vld_sr_q;
  logic [L-1:0] first_sr_d, first_sr_q;
  logic [L-1:0] last_sr_d, last_sr_q;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [OUT_W-1:0]        acc_o_d, acc_o_q;
  logic [CNT_W-1:0]        cnt_o_d, cnt_o_q;
  logic                    ovf_d, ovf_q;
  logic                    vld_o_d, vld_o_q;

  logic                    tv_s, tf_s, tl_s;
  logic signed [ACC_W-1:0] s_ext_s, acc_next_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic [OUT_W-1:0]        res_nar_s;
  logic                    res_ovf_s;

  // Gather operands per level: level 0 is the sign-extended input lanes, others the tree flops.
  always_comb begin
    lvl_s = '{default: '0};
    for (int k = 0; k < NUM_IN; k++) begin
      lvl_s[0][k] = tw_t'($signed(din[k*IN_W +: IN_W]));
    end
    for (int l = 1; l <= L; l++) begin
      for (int k = 0; k < NUM_IN; k++) begin
        lvl_s[l][k] = tree_q[l][k];
      end
    end
  end

  // Pairwise reduction per level; an odd leftover operand passes through unchanged.
  always_comb begin
    int n;
    tree_d = '{default: '0};
    n = NUM_IN;
    for (int l = 1; l <= L; l++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (2*i + 1 < n) begin
          tree_d[l][i] = lvl_s[l-1][2*i] + lvl_s[l-1][2*i+1];
        end else if (2*i < n) begin
          tree_d[l][i] = lvl_s[l-1][2*i];
        end else begin
          tree_d[l][i] = '0;
        end
      end
      n = (n + 1) / 2;
    end
  end

  // Tree pipeline registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tree_q <= '{default: '0};
    end else begin
      tree_q <= tree_d;
    end
  end

  // Control shift register aligned with the tree; flags only meaningful on valid beats.
  always_comb begin
    vld_sr_d      = '0;
    first_sr_d    = '0;
    last_sr_d     = '0;
    vld_sr_d[0]   = vld_i;
    first_sr_d[0] = vld_i & first_i;
    last_sr_d[0]  = vld_i & last_i;
    for (int k = 1; k < L; k++) begin
      vld_sr_d[k]   = vld_sr_q[k-1];
      first_sr_d[k] = first_sr_q[k-1];
      last_sr_d[k]  = last_sr_q[k-1];
    end
  end

  // Control shift register flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr_q   <= '0;
      first_sr_q <= '0;
      last_sr_q  <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      first_sr_q <= first_sr_d;
      last_sr_q  <= last_sr_d;
    end
  end

  assign tv_s    = vld_sr_q[L-1];
  assign tf_s    = first_sr_q[L-1];
  assign tl_s    = last_sr_q[L-1];
  assign s_ext_s = ACC_W'(lvl_s[L][0]);

  // Accumulator next value: a first beat restarts from the tree sum, otherwise add with wrap.
  always_comb begin
    if (tf_s) begin
      acc_next_s = s_ext_s;
      cnt_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_next_s = acc_q + s_ext_s;
      cnt_next_s = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Narrow the group result to the output width (clamp or wrap depending on build).
  always_comb begin
`ifdef ADDER_TREE_ACC_SAT_EN
    if (acc_next_s > SAT_MAX) begin
      res_nar_s = SAT_MAX[OUT_W-1:0];
      res_ovf_s = 1'b1;
    end else if (acc_next_s < SAT_MIN) begin
      res_nar_s = SAT_MIN[OUT_W-1:0];
      res_ovf_s = 1'b1;
    end else begin
      res_nar_s = acc_next_s[OUT_W-1:0];
      res_ovf_s = 1'b0;
    end
`else
    res_nar_s = acc_next_s[OUT_W-1:0];
    res_ovf_s = 1'b0;
`endif
  end

  // Accumulator/output update: hold on bubbles, emit and clear on a last beat.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    acc_o_d = acc_o_q;
    cnt_o_d = cnt_o_q;
    ovf_d   = ovf_q;
    vld_o_d = 1'b0;
    if (tv_s) begin
      if (tl_s) begin
        acc_d   = '0;
        cnt_d   = '0;
        acc_o_d = res_nar_s;
        cnt_o_d = cnt_next_s;
        ovf_d   = res_ovf_s;
        vld_o_d = 1'b1;
      end else begin
        acc_d = acc_next_s;
        cnt_d = cnt_next_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      acc_o_q <= '0;
      cnt_o_q <= '0;
      ovf_q   <= 1'b0;
      vld_o_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      acc_o_q <= acc_o_d;
      cnt_o_q <= cnt_o_d;
      ovf_q   <= ovf_d;
      vld_o_q <= vld_o_d;
    end
  end

  assign acc_o      = acc_o_q;
  assign cnt_o      = cnt_o_q;
  assign ovf_o      = ovf_q;
  assign vld_o      = vld_o_q;
  assign vld_o_prev = tv_s & tl_s;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc (NUM_IN=9, IN_W=16, ACC_W=24, OUT_W=20, CNT_W=8).
module tb_adder_tree_acc;

  logic         clk = 1'b0;
  logic         rstn;
  logic         vld_i, first_i, last_i;
  logic [143:0] din;
  logic [19:0]  acc_o;
  logic [7:0]   cnt_o;
  logic         ovf_o, vld_o, vld_o_prev;

  adder_tree_acc #(.NUM_IN(9), .IN_W(16), .ACC_W(24), .OUT_W(20), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
    .din(din), .acc_o(acc_o), .cnt_o(cnt_o), .ovf_o(ovf_o), .vld_o(vld_o),
    .vld_o_prev(vld_o_prev)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int last_vld_cyc = -10;
  int prev_vld_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop expected result whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (vld_o === 1'b1) begin
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
      vld_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld_o: got acc=%0h cnt=%0h expected no output", acc_o, cnt_o);
      end else begin
        e = q.pop_front();
        chk("acc_o", {12'd0, acc_o}, {12'd0, e.acc});
        chk("cnt_o", {24'd0, cnt_o}, {24'd0, e.cnt});
        chk("ovf_o", {31'd0, ovf_o}, {31'd0, e.ovf});
      end
    end
  end

  task automatic expect_res(input logic [19:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    q.push_back(e);
  endtask

  task automatic beat(input logic v, input logic f, input logic l, input logic [15:0] val);
    @(negedge clk);
    vld_i = v; first_i = f; last_i = l;
    din = {9{val}};
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_acc"},  {12'd0, acc_o}, 32'd0);
    chk({tag, "_cnt"},  {24'd0, cnt_o}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, ovf_o}, 32'd0);
    chk({tag, "_vld"},  {31'd0, vld_o}, 32'd0);
    chk({tag, "_prev"}, {31'd0, vld_o_prev}, 32'd0);
  endtask

  initial begin
    int vc0;
    int w;
    rstn = 1'b0; vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // 1: single beat of ones, latency of vld_o_prev and vld_o
    expect_res(20'd9, 8'd1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 16'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; din = '0;
      end
      chk($sformatf("t1_prev_at_%0d", k), {31'd0, vld_o_prev}, {31'd0, (k == 4)});
      chk($sformatf("t1_vld_at_%0d", k),  {31'd0, vld_o},      {31'd0, (k == 5)});
    end

    // 2: most negative lanes
    expect_res(20'hB8000, 8'd1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 16'h8000);
    idle(8);

    // 3: three beats with idle gaps
    expect_res(20'd2700, 8'd3, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 16'd100);
    idle(2);
    beat(1'b1, 1'b0, 1'b0, 16'd100);
    idle(1);
    beat(1'b1, 1'b0, 1'b1, 16'd100);
    idle(8);

    // 4: four beats of max positive lanes, exceeds OUT_W
`ifdef ADDER_TREE_ACC_SAT_EN
    expect_res(20'h7FFFF, 8'd4, 1'b1);
`else
    expect_res(20'h1FFDC, 8'd4, 1'b0);
`endif
    beat(1'b1, 1'b1, 1'b0, 16'h7FFF);
    beat(1'b1, 1'b0, 1'b0, 16'h7FFF);
    beat(1'b1, 1'b0, 1'b0, 16'h7FFF);
    beat(1'b1, 1'b0, 1'b1, 16'h7FFF);
    idle(8);

    // 5: group restarted by a mid-group first, then back-to-back group
    vc0 = vld_cnt;
    expect_res(20'd18, 8'd1, 1'b0);
    expect_res(20'd27, 8'd1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 16'd5);
    beat(1'b1, 1'b0, 1'b0, 16'd5);
    beat(1'b1, 1'b1, 1'b1, 16'd2);
    beat(1'b1, 1'b1, 1'b1, 16'd3);
    idle(8);
    chk("t5_pulses", vld_cnt - vc0, 32'd2);
    chk("t5_consecutive", last_vld_cyc - prev_vld_cyc, 32'd1);

    // Flags on a bubble are ignored; group without first starts from zero
    expect_res(20'd36, 8'd1, 1'b0);
    beat(1'b0, 1'b1, 1'b1, 16'd7);
    beat(1'b1, 1'b0, 1'b1, 16'd4);
    idle(8);

    // Distinct mixed-sign lanes: 100*k*k - 1000, sum 11400 (exercises odd leftover lane)
    expect_res(20'd11400, 8'd1, 1'b0);
    @(negedge clk);
    vld_i = 1'b1; first_i = 1'b1; last_i = 1'b1;
    for (int k = 0; k < 9; k++) din[k*16 +: 16] = 16'(100*k*k - 1000);
    idle(8);

    // Counter saturation: 300 beats of ones
    expect_res(20'd2700, 8'd255, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 16'd1);
    repeat (298) beat(1'b1, 1'b0, 1'b0, 16'd1);
    beat(1'b1, 1'b0, 1'b1, 16'd1);
    idle(8);

    // 6: reset mid-group drops in-flight beats and clears outputs
    beat(1'b1, 1'b1, 1'b0, 16'd5);
    beat(1'b1, 1'b0, 1'b1, 16'd5);
    @(negedge clk);
    vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0; din = '0;
    rstn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_zero($sformatf("t6_rst%0d", k));
    end
    rstn = 1'b1;
    expect_res(20'd9, 8'd1, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 16'd1);
    idle(8);

    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
